// File: rtl/buf_ex_rd_ctrl.sv
// Execute-side read sequencer for the ping-pong tile buffer: waits for a full bank,
// reads a tile through the 1-cycle-latency port, streams it out, then releases the bank.
// Optional feature macro: BUF_RD_REPLAY_EN (adds rd_rep; each bank is streamed rd_rep+1 times).
module buf_ex_rd_ctrl #(
  parameter int BUF_EX_ADDR_WIDTH = 10,
  parameter int BUF_EX_DATA_WIDTH = 8,
  parameter int LEN_WIDTH         = BUF_EX_ADDR_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         tile_len,
`ifdef BUF_RD_REPLAY_EN
  input  logic [7:0]                   rd_rep,
`endif
  input  logic                         ld_commit,
  input  logic                         ld_commit_sel,
  output logic [1:0]                   bank_full,
  output logic                         buf_ex_sel,
  output logic [BUF_EX_ADDR_WIDTH-1:0] buf_ex_addr,
  input  logic [BUF_EX_DATA_WIDTH-1:0] buf_ex_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [BUF_EX_DATA_WIDTH-1:0] m_data,
  output logic                         m_last,
  output logic                         busy,
  output logic                         done,
  output logic                         commit_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN} state_t;

  state_t                       r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0]         r_len;
  logic [BUF_EX_ADDR_WIDTH-1:0] r_addr;
  logic [1:0]                   r_bank_full;
  logic                         r_sel;
  logic                         r_inflight, r_inflight_last, r_inflight_fin;
  logic [BUF_EX_DATA_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]                   r_fifo_last, r_fifo_fin;
  logic                         r_wptr, r_rptr;
  logic [1:0]                   r_count;
  logic                         r_busy, r_done, r_commit_err;

  logic                         w_accept, w_zero_start, w_issue, w_release;
  logic                         w_push, w_pop, w_room, w_addr_last, w_pass_final, w_err;
  logic [LEN_WIDTH-1:0]         w_len_m1;
  logic [1:0]                   w_set_mask, w_clr_mask;

`ifdef BUF_RD_REPLAY_EN
  logic [7:0] r_rep, r_pass;
  assign w_pass_final = (r_pass == r_rep);
`else
  assign w_pass_final = 1'b1;
`endif

  assign w_len_m1    = r_len - LEN_WIDTH'(1);
  assign w_addr_last = (LEN_WIDTH'(r_addr) == w_len_m1);
  // Reads in flight count against the 2-entry skid FIFO so it can never overflow.
  assign w_room      = ({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2;
  assign w_push      = r_inflight;
  assign w_pop       = m_valid && m_ready;
  assign w_set_mask  = ld_commit ? (ld_commit_sel ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr_mask  = w_release ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
  // A commit landing on the bank being released in the same cycle is legal.
  assign w_err       = ld_commit && r_bank_full[ld_commit_sel] &&
                       !(w_release && (ld_commit_sel == r_sel));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_WAIT;
      S_WAIT:  if (r_bank_full[r_sel]) w_state_nxt = S_READ;
      S_READ:  if (w_issue && w_addr_last && w_pass_final) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_release) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept     = 1'b0;
    w_zero_start = 1'b0;
    w_issue      = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept     = start && (tile_len != '0);
        w_zero_start = start && (tile_len == '0);
      end
      S_READ:  w_issue   = w_room;
      S_DRAIN: w_release = w_pop && r_fifo_fin[r_rptr];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len           <= '0;
      r_addr          <= '0;
      r_bank_full     <= 2'b00;
      r_sel           <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_inflight_fin  <= 1'b0;
      r_fifo_data[0]  <= '0;
      r_fifo_data[1]  <= '0;
      r_fifo_last     <= 2'b00;
      r_fifo_fin      <= 2'b00;
      r_wptr          <= 1'b0;
      r_rptr          <= 1'b0;
      r_count         <= 2'd0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_commit_err    <= 1'b0;
`ifdef BUF_RD_REPLAY_EN
      r_rep           <= '0;
      r_pass          <= '0;
`endif
    end else begin
      if (w_accept) r_len <= tile_len;
`ifdef BUF_RD_REPLAY_EN
      if (w_accept) begin
        r_rep  <= rd_rep;
        r_pass <= '0;
      end else if (w_issue && w_addr_last && !w_pass_final) begin
        r_pass <= r_pass + 8'd1;
      end
`endif
      // The counter folds back to 0 after the last address, so it never passes tile_len-1.
      if (r_state == S_WAIT)  r_addr <= '0;
      else if (w_issue)       r_addr <= w_addr_last ? '0 : r_addr + 1'b1;

      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_addr_last;
      r_inflight_fin  <= w_issue && w_addr_last && w_pass_final;

      if (w_push) begin
        r_fifo_data[r_wptr] <= buf_ex_data;
        r_fifo_last[r_wptr] <= r_inflight_last;
        r_fifo_fin[r_wptr]  <= r_inflight_fin;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

      r_bank_full  <= (r_bank_full & ~w_clr_mask) | w_set_mask;
      if (w_release) r_sel <= ~r_sel;
      if (w_accept)       r_busy <= 1'b1;
      else if (w_release) r_busy <= 1'b0;
      r_done       <= w_release || w_zero_start;
      r_commit_err <= r_commit_err | w_err;
    end
  end

  assign bank_full   = r_bank_full;
  assign buf_ex_sel  = r_sel;
  assign buf_ex_addr = r_addr;
  assign m_valid     = (r_count != 2'd0);
  assign m_data      = r_fifo_data[r_rptr];
  assign m_last      = m_valid && r_fifo_last[r_rptr];
  assign busy        = r_busy;
  assign done        = r_done;
  assign commit_err  = r_commit_err;

endmodule
